// File: rtl/mul_arbiter.sv
// ---------------------------------------------------------------------------
// mul_arbiter
//   Shares one external pipelined 8x8 multiplier among NUM_REQ requesters.
//   A round-robin arbiter issues at most one op per cycle. An internal
//   valid/ID shift pipe tracks in-flight ops; the multiplier's done output is
//   not used. Each product is captured with its requester ID into a response
//   FIFO. A credit check (FIFO occupancy + in-flight ops < FIFO_DEPTH) means
//   every issued op is guaranteed a FIFO slot on arrival.
//
//   Optional feature macro: MUL_ARB_STATS_EN adds saturating counters
//   stat_issued_o / stat_stall_o. With the macro undefined, the ports and
//   counters do not exist and arbitration is unchanged.
//
// Parameters
//   NUM_REQ     number of requesters (2..8)
//   MUL_LAT     issue-to-capture latency of the multiplier (>= 2)
//   FIFO_DEPTH  response FIFO entries (power of 2, >= MUL_LAT)
//
// Ports
//   clk, rst_n           clock, async active-low reset (sync release)
//   req_valid_i          per-requester op valid
//   req_ready_o          per-requester grant (one-hot or zero)
//   req_a_i, req_b_i     operands, requester i at [8i+7:8i]
//   mul_start_o          issue strobe to multiplier
//   mul_opcode_o         3'b100 on issue, else 3'b000
//   mul_a_o, mul_b_o     operands to multiplier (0 when idle)
//   mul_result_i         multiplier product
//   rsp_valid_o          FIFO head valid
//   rsp_ready_i          consumer accepts head
//   rsp_id_o             requester index of head
//   rsp_result_o         product at head
//   stat_issued_o        (MUL_ARB_STATS_EN) issue count, saturating
//   stat_stall_o         (MUL_ARB_STATS_EN) stalled-request cycles, saturating
// ---------------------------------------------------------------------------
module mul_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int MUL_LAT    = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
`ifdef MUL_ARB_STATS_EN
    output logic [31:0]                stat_issued_o,
    output logic [31:0]                stat_stall_o,
`endif
    input  logic [NUM_REQ-1:0]         req_valid_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    input  logic [NUM_REQ*8-1:0]       req_a_i,
    input  logic [NUM_REQ*8-1:0]       req_b_i,
    output logic                       mul_start_o,
    output logic [2:0]                 mul_opcode_o,
    output logic [7:0]                 mul_a_o,
    output logic [7:0]                 mul_b_o,
    input  logic [15:0]                mul_result_i,
    output logic                       rsp_valid_o,
    input  logic                       rsp_ready_i,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id_o,
    output logic [15:0]                rsp_result_o
);
    localparam int ID_W   = $clog2(NUM_REQ);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    // The issue cycle itself is stage 0 (combinational); the remaining
    // MUL_LAT-1 stages are registered, the last one feeding the FIFO push.
    localparam int PIPE_N = MUL_LAT - 1;

    // ---------------- operand unpacking ----------------
    logic [7:0] op_a [NUM_REQ];
    logic [7:0] op_b [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign op_a[gi] = req_a_i[8*gi +: 8];
            assign op_b[gi] = req_b_i[8*gi +: 8];
        end
    endgenerate

    // ---------------- state ----------------
    logic [ID_W-1:0]  rr_q, rr_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PIPE_N-1:0] pipe_vld_q;
    logic [ID_W-1:0]  pipe_id_q [PIPE_N];
    logic [ID_W+15:0] fifo_mem [FIFO_DEPTH];

    logic             credit_ok;
    logic [CNT_W:0]   outstanding;
    logic             grant_any;
    logic [ID_W-1:0]  grant_id;
    logic [ID_W:0]    scan_sum;
    logic [ID_W-1:0]  scan_idx;
    logic             push, pop;
    logic [ID_W-1:0]  push_id;
    logic [ID_W+15:0] head;

    // Same-cycle pops are deliberately not credited: credit only looks at
    // registered counts, so grants never depend on rsp_ready combinationally.
    assign outstanding = {1'b0, fifo_cnt_q} + {1'b0, inflight_q};
    assign credit_ok   = outstanding < (CNT_W+1)'(FIFO_DEPTH);

    // ---------------- round-robin arbiter ----------------
    // Grants are gated by rst_n so every output reads 0 while reset is held.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        scan_sum  = '0;
        scan_idx  = '0;
        if (rst_n && credit_ok) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                scan_sum = {1'b0, rr_q} + (ID_W+1)'(k);
                if (scan_sum >= (ID_W+1)'(NUM_REQ))
                    scan_sum = scan_sum - (ID_W+1)'(NUM_REQ);
                scan_idx = scan_sum[ID_W-1:0];
                if (!grant_any && req_valid_i[scan_idx]) begin
                    grant_any = 1'b1;
                    grant_id  = scan_idx;
                end
            end
        end
    end

    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready_o[gi] = grant_any && (grant_id == ID_W'(gi));
        end
    endgenerate

    assign rr_d = !grant_any                     ? rr_q :
                  (grant_id == ID_W'(NUM_REQ-1)) ? '0   : grant_id + ID_W'(1);

    assign mul_start_o  = grant_any;
    assign mul_opcode_o = grant_any ? 3'b100 : 3'b000;
    assign mul_a_o      = grant_any ? op_a[grant_id] : 8'h00;
    assign mul_b_o      = grant_any ? op_b[grant_id] : 8'h00;

    // ---------------- in-flight tracking ----------------
    assign push       = pipe_vld_q[PIPE_N-1];
    assign push_id    = pipe_id_q[PIPE_N-1];
    assign inflight_d = inflight_q + CNT_W'(grant_any) - CNT_W'(push);

    // ---------------- response FIFO ----------------
    assign rsp_valid_o  = (fifo_cnt_q != '0);
    assign pop          = rsp_valid_o && rsp_ready_i;
    assign fifo_cnt_d   = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
    assign head         = fifo_mem[rd_ptr_q];
    // Stale RAM contents are masked so the response outputs are 0 when empty.
    assign rsp_id_o     = rsp_valid_o ? head[ID_W+15:16] : '0;
    assign rsp_result_o = rsp_valid_o ? head[15:0]       : 16'h0000;

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr_q] <= {push_id, mul_result_i};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q       <= '0;
            inflight_q <= '0;
            fifo_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            pipe_vld_q <= '0;
            for (int s = 0; s < PIPE_N; s++)
                pipe_id_q[s] <= '0;
        end else begin
            rr_q          <= rr_d;
            inflight_q    <= inflight_d;
            fifo_cnt_q    <= fifo_cnt_d;
            pipe_vld_q[0] <= grant_any;
            pipe_id_q[0]  <= grant_id;
            for (int s = 1; s < PIPE_N; s++) begin
                pipe_vld_q[s] <= pipe_vld_q[s-1];
                pipe_id_q[s]  <= pipe_id_q[s-1];
            end
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

`ifdef MUL_ARB_STATS_EN
    // ---------------- statistics ----------------
    logic [31:0] stat_issued_q, stat_stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_issued_q <= '0;
            stat_stall_q  <= '0;
        end else begin
            if (grant_any && (stat_issued_q != 32'hFFFF_FFFF))
                stat_issued_q <= stat_issued_q + 32'd1;
            if ((|req_valid_i) && !grant_any && (stat_stall_q != 32'hFFFF_FFFF))
                stat_stall_q <= stat_stall_q + 32'd1;
        end
    end

    assign stat_issued_o = stat_issued_q;
    assign stat_stall_o  = stat_stall_q;
`endif

    // Credit should make an overflowing push impossible.
    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && (fifo_cnt_q == CNT_W'(FIFO_DEPTH))));
    a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(req_ready_o));

endmodule

// File: tb/tb_mul_arbiter.sv
`timescale 1ns/1ps
module tb_mul_arbiter;
    localparam int NUM_REQ    = 4;
    localparam int MUL_LAT    = 4;
    localparam int FIFO_DEPTH = 8;
    localparam int ID_W       = $clog2(NUM_REQ);

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [NUM_REQ-1:0]    req_valid = '1;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*8-1:0]  req_a = '1;
    logic [NUM_REQ*8-1:0]  req_b = '1;
    logic                  mul_start;
    logic [2:0]            mul_opcode;
    logic [7:0]            mul_a, mul_b;
    logic [15:0]           mul_result;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b1;
    logic [ID_W-1:0]       rsp_id;
    logic [15:0]           rsp_result;
`ifdef MUL_ARB_STATS_EN
    logic [31:0]           stat_issued, stat_stall;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    mul_arbiter #(.NUM_REQ(NUM_REQ), .MUL_LAT(MUL_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
`ifdef MUL_ARB_STATS_EN
        .stat_issued_o(stat_issued),
        .stat_stall_o (stat_stall),
`endif
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .mul_start_o  (mul_start),
        .mul_opcode_o (mul_opcode),
        .mul_a_o      (mul_a),
        .mul_b_o      (mul_b),
        .mul_result_i (mul_result),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_id_o     (rsp_id),
        .rsp_result_o (rsp_result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Environment multiplier: product of an issue in cycle t is on mul_result in t+MUL_LAT-1.
    logic [15:0] mp [MUL_LAT-1];
    always @(posedge clk) begin
        mp[0] <= mul_start ? ({8'h00, mul_a} * {8'h00, mul_b}) : 16'h0000;
        for (int i = 1; i < MUL_LAT-1; i++) mp[i] <= mp[i-1];
    end
    assign mul_result = mp[MUL_LAT-2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model / scoreboard ----------------
    typedef struct { int id; int prod; int vis; } exp_t;
    exp_t exp_q[$];
    int   m_rr = 0;
    int   m_id;
    int   m_issued = 0;
    int   m_stall  = 0;
    int   dut_grants = 0;
    logic [NUM_REQ-1:0] exp_ready;

    // Arbitration checker / producer: every op issued but not yet consumed
    // holds one credit, so outstanding work is simply the scoreboard depth.
    always @(negedge clk) begin
        if (rst_n) begin
            m_id = -1;
            if (exp_q.size() < FIFO_DEPTH) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    int idx;
                    idx = (m_rr + k) % NUM_REQ;
                    if (m_id < 0 && req_valid[idx]) m_id = idx;
                end
            end
            exp_ready = '0;
            if (m_id >= 0) exp_ready[m_id] = 1'b1;
            if (|(req_ready & req_valid)) dut_grants++;
            check("req_ready", 32'(req_ready), 32'(exp_ready));
            check("mul_start", 32'(mul_start), (m_id >= 0) ? 32'd1 : 32'd0);
            if (m_id >= 0) begin
                exp_t e;
                check("mul_opcode", 32'(mul_opcode), 32'd4);
                check("mul_a", 32'(mul_a), 32'(req_a[8*m_id +: 8]));
                check("mul_b", 32'(mul_b), 32'(req_b[8*m_id +: 8]));
                e.id   = m_id;
                e.prod = int'(req_a[8*m_id +: 8]) * int'(req_b[8*m_id +: 8]);
                e.vis  = cyc + MUL_LAT;
                exp_q.push_back(e);
                m_rr = (m_id + 1) % NUM_REQ;
                m_issued++;
            end else begin
                check("mul_idle", {21'd0, mul_opcode, mul_a}, 32'd0);
                check("mul_b_idle", 32'(mul_b), 32'd0);
                if (|req_valid) m_stall++;
            end
        end
    end

    // Response monitor: runs after the checker in each cycle.
    logic exp_vld;
    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            exp_vld = (exp_q.size() > 0) && (exp_q[0].vis <= cyc);
            check("rsp_valid", 32'(rsp_valid), 32'(exp_vld));
            if (rsp_valid && exp_vld) begin
                check("rsp_id", 32'(rsp_id), 32'(exp_q[0].id));
                check("rsp_result", 32'(rsp_result), 32'(exp_q[0].prod));
            end
            if (rsp_valid && rsp_ready && exp_q.size() > 0) begin
                $display("rsp id=%0d result=%04h cycle=%0d", rsp_id, rsp_result, cyc);
                void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        m_rr = 0;
        m_issued = 0;
        m_stall = 0;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_mul_start", 32'(mul_start), 32'd0);
        check("rst_mul_opcode", 32'(mul_opcode), 32'd0);
        check("rst_mul_ab", {16'd0, mul_a, mul_b}, 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_rsp_result", 32'(rsp_result), 32'd0);
`ifdef MUL_ARB_STATS_EN
        check("rst_stat_issued", stat_issued, 32'd0);
        check("rst_stat_stall", stat_stall, 32'd0);
`endif
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_a[8*i +: 8] = 8'($urandom);
            req_b[8*i +: 8] = 8'($urandom);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] t3a [3];
        logic [7:0] t3b [3];
        int waitc;
        t3a[0] = 8'd255; t3b[0] = 8'd255;
        t3a[1] = 8'd0;   t3b[1] = 8'd200;
        t3a[2] = 8'd1;   t3b[2] = 8'd128;

        // Reset with every requester asking: outputs must still read 0.
        do_reset();

        // Single request from requester 2.
        req_valid = '0;
        next_cycle();
        req_valid = 4'b0100;
        req_a[23:16] = 8'd12;
        req_b[23:16] = 8'd13;
        next_cycle();
        req_valid = '0;
        repeat (6) next_cycle();

        // All requesters continuously: 0,1,2,3,... with no bubbles.
        do_reset();
        for (int c = 0; c < 12; c++) begin
            req_valid = '1;
            rand_ops();
            next_cycle();
        end
        req_valid = '0;
        repeat (6) next_cycle();

        // Boundary products from requester 0.
        for (int i = 0; i < 3; i++) begin
            req_valid = 4'b0001;
            req_a[7:0] = t3a[i];
            req_b[7:0] = t3b[i];
            next_cycle();
        end
        req_valid = '0;
        repeat (6) next_cycle();

        // Backpressure until full, then drain.
        do_reset();
        req_valid = '1;
        rsp_ready = 1'b0;
        rand_ops();
        dut_grants = 0;
        repeat (20) next_cycle();
        check("full_issue_count", 32'(dut_grants), 32'd8);
        check("full_req_ready", 32'(req_ready), 32'd0);
        check("full_rsp_valid", 32'(rsp_valid), 32'd1);
`ifdef MUL_ARB_STATS_EN
        check("stat_issued", stat_issued, 32'd8);
        check("stat_stall", stat_stall, 32'd12);
`endif
        rsp_ready = 1'b1;
        repeat (20) next_cycle();
        req_valid = '0;
        repeat (8) next_cycle();

        // Reset with 3 ops in flight.
        do_reset();
        req_valid = '1;
        rand_ops();
        repeat (3) next_cycle();
        #2;
        do_reset();
        next_cycle();
        req_valid = '0;
        repeat (8) next_cycle();

        // Randomized traffic with random backpressure.
        for (int c = 0; c < 400; c++) begin
            req_valid = NUM_REQ'($urandom);
            rand_ops();
            rsp_ready = ($urandom_range(0, 3) != 0);
            next_cycle();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        waitc = 0;
        while (exp_q.size() > 0 && waitc < 100) begin
            next_cycle();
            waitc++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        next_cycle();
`ifdef MUL_ARB_STATS_EN
        check("stat_issued_final", stat_issued, 32'(m_issued));
        check("stat_stall_final", stat_stall, 32'(m_stall));
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
